// File: rtl/homin_mult_scheduler_pkg.sv
// Shared definitions for the HOMIN multiplier scheduler.
//   state_e    : scheduler FSM encoding
//   MULT_ITERS : iterations the shared CORDIC multiplier needs per job
//   OP_W       : signed Q4.4 operand width
//   RES_W      : raw multiplier result width
package homin_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int MULT_ITERS = 9;
  localparam int OP_W       = 8;
  localparam int RES_W      = 16;

endpackage

// File: rtl/homin_mult_scheduler_if.sv
// Bundle between the neuron requesters, the scheduler and the shared
// multiplier.
//   slave  : scheduler side (takes requests and mult results, drives grants,
//            responses and the multiplier operands)
//   master : environment side (requesters plus multiplier)
interface homin_mult_scheduler_if
  import homin_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);

  logic [NUM_REQ-1:0]      req_valid;
  logic [OP_W*NUM_REQ-1:0] req_operand;
  logic [NUM_REQ-1:0]      req_ready;
  logic                    rsp_valid;
  logic [ID_W-1:0]         rsp_id;
  logic [RES_W-1:0]        rsp_data;
  logic                    rsp_err;
  logic                    mult_start;
  logic [OP_W-1:0]         mult_x;
  logic [OP_W-1:0]         mult_z;
  logic [RES_W-1:0]        mult_y;
  logic                    mult_done;

  modport slave (
    input  req_valid, req_operand, mult_y, mult_done,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
           mult_start, mult_x, mult_z
  );

  modport master (
    output req_valid, req_operand, mult_y, mult_done,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
           mult_start, mult_x, mult_z
  );

endinterface

// File: rtl/homin_mult_scheduler_rr_pick.sv
// Rotating-priority encoder: the first set request strictly after ptr_i
// (wrapping) wins.
//   req_i   : request vector
//   ptr_i   : index of the last winner
//   grant_o : one-hot winner (zero when no request)
//   idx_o   : index of the winner
module homin_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    idx_o
);

  int j;

  // Walk from the farthest candidate to the nearest so the nearest set bit
  // after ptr_i is the last one written.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    j       = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = (int'(ptr_i) + k) % NUM_REQ;
      if (req_i[j]) begin
        grant_o    = '0;
        grant_o[j] = 1'b1;
        idx_o      = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/homin_mult_scheduler.sv
// Shares one iterative CORDIC multiplier among NUM_REQ requesters. Each job
// squares a latched Q4.4 operand and returns the raw product tagged with the
// requester id; a watchdog aborts jobs whose done never arrives.
//   clk, rst    : clock, synchronous active-high reset
//   bus         : requests, responses and multiplier handshake (slave side)
//   busy        : job in flight (RUN or RESP)
//   timeout_err : sticky abort flag, cleared only by rst
//
// state | meaning
// IDLE  | waiting for a request
// RUN   | multiplier running, watchdog counting
// RESP  | response strobe, mult_start held low
module homin_mult_scheduler
  import homin_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  homin_mult_scheduler_if.slave   bus,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [RES_W-1:0]   rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic               start_q, start_d;
  logic               busy_q, busy_d;
  logic               terr_q, terr_d;

  logic [NUM_REQ-1:0] pick_grant;
  logic [ID_W-1:0]    pick_idx;

  homin_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req_i   (bus.req_valid),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= ID_W'(NUM_REQ - 1);
      id_q        <= '0;
      op_q        <= '0;
      cnt_q       <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      terr_q      <= terr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    req_ready_d = '0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = 1'b0;
    start_d     = 1'b0;
    terr_d      = terr_q;

    unique case (state_q)
      // RESP arbitrates as well as IDLE: the RESP cycle is already the
      // start-low gap, so the next grant can follow it directly and keep
      // back-to-back jobs 12 cycles apart.
      ST_IDLE, ST_RESP: begin
        state_d = ST_IDLE;
        if (|bus.req_valid) begin
          req_ready_d = pick_grant;
          id_d        = pick_idx;
          ptr_d       = pick_idx;
          op_d        = bus.req_operand[int'(pick_idx)*OP_W +: OP_W];
          cnt_d       = '0;
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.mult_done) begin
          rsp_data_d  = bus.mult_y;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          terr_d      = 1'b1;
          state_d     = ST_RESP;
        end else begin
          start_d = 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.mult_start = start_q;
  assign bus.mult_x     = op_q;
  assign bus.mult_z     = op_q;
  assign busy           = busy_q;
  assign timeout_err    = terr_q;

endmodule
